// File: rtl/mem_responder_if.sv
// Cache-request / RAM bus bundle for the shared-memory responder.
// slave = responder side, master = caches plus RAM model.
interface mem_responder_if #(parameter int NCPU = 2);
   logic [NCPU-1:0]      iREN;
   logic [32*NCPU-1:0]   iaddr;
   logic [NCPU-1:0]      iwait;
   logic [32*NCPU-1:0]   iload;
   logic [NCPU-1:0]      dREN;
   logic [NCPU-1:0]      dWEN;
   logic [32*NCPU-1:0]   daddr;
   logic [32*NCPU-1:0]   dstore;
   logic [NCPU-1:0]      dwait;
   logic [32*NCPU-1:0]   dload;
   logic                 ramREN;
   logic                 ramWEN;
   logic [31:0]          ramaddr;
   logic [31:0]          ramstore;
   logic [31:0]          ramload;
   logic [1:0]           ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_responder.sv
// Serves per-core icache/dcache word requests one at a time on a single RAM port.
//   state  | meaning
//   IDLE   | arbitrate pending requests, latch the winner, no strobes
//   ACCESS | drive RAM strobes from latched request until done/error/timeout/withdraw
module mem_responder #(
   parameter int NCPU    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic            CLK,
   input  logic            RST,
   mem_responder_if.slave  bus,
   output logic [7:0]      errcnt
);
   typedef enum logic {IDLE, ACCESS} state_t;

   localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   state_t              state, state_nxt;
   logic [CW-1:0]       core_q, rr_ptr;
   logic                src_d_q, wr_q;
   logic [31:0]         addr_q, data_q;
   logic [TW-1:0]       tmo_cnt;
   logic [32*NCPU-1:0]  iload_q, dload_q;

   logic [NCPU-1:0]     dreq;
   logic [CW:0]         cand;
   logic                arb_valid, arb_d, arb_w;
   logic [CW-1:0]       arb_core;
   logic [31:0]         arb_addr, arb_data;
   logic                req_held, done, abort_err, abort_wd;

   assign dreq = bus.dREN | bus.dWEN;

   // dcache round-robin from rr_ptr first, then icache fixed lowest-index
   always_comb begin
      arb_valid = 1'b0;
      arb_d     = 1'b0;
      arb_w     = 1'b0;
      arb_core  = '0;
      cand      = '0;
      for (int i = 0; i < NCPU; i++) begin
         cand = {1'b0, rr_ptr} + (CW+1)'(i);
         if (cand >= (CW+1)'(NCPU))
            cand = cand - (CW+1)'(NCPU);
         if (!arb_valid && dreq[cand[CW-1:0]]) begin
            arb_valid = 1'b1;
            arb_d     = 1'b1;
            arb_core  = cand[CW-1:0];
            arb_w     = bus.dWEN[cand[CW-1:0]];
         end
      end
      for (int i = 0; i < NCPU; i++) begin
         if (!arb_valid && bus.iREN[i]) begin
            arb_valid = 1'b1;
            arb_core  = CW'(i);
         end
      end
      arb_addr = arb_d ? bus.daddr[32*arb_core +: 32] : bus.iaddr[32*arb_core +: 32];
      arb_data = arb_d ? bus.dstore[32*arb_core +: 32] : 32'd0;
   end

   assign req_held  = src_d_q ? dreq[core_q] : bus.iREN[core_q];
   assign abort_wd  = (state == ACCESS) && !req_held;
   assign abort_err = (state == ACCESS) && req_held &&
                      ((bus.ramstate == RAM_ERROR) ||
                       ((bus.ramstate != RAM_ACCESS) && (tmo_cnt == TW'(TIMEOUT-1))));
   // a reset cycle never acknowledges, even if RAM answers
   assign done      = (state == ACCESS) && req_held && (bus.ramstate == RAM_ACCESS) && !RST;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arb_valid) state_nxt = ACCESS;
         ACCESS:  if (done || abort_err || abort_wd) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.iwait = '1;
      bus.dwait = '1;
      bus.iload = iload_q;
      bus.dload = dload_q;
      if (done) begin
         if (src_d_q) begin
            bus.dwait[core_q] = 1'b0;
            if (!wr_q) bus.dload[32*core_q +: 32] = bus.ramload;
         end else begin
            bus.iwait[core_q] = 1'b0;
            if (!wr_q) bus.iload[32*core_q +: 32] = bus.ramload;
         end
      end
   end

   assign bus.ramREN   = (state == ACCESS) && !wr_q;
   assign bus.ramWEN   = (state == ACCESS) && wr_q;
   assign bus.ramaddr  = (state == ACCESS) ? addr_q : 32'd0;
   assign bus.ramstore = ((state == ACCESS) && wr_q) ? data_q : 32'd0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         core_q  <= '0;
         rr_ptr  <= '0;
         src_d_q <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         tmo_cnt <= '0;
         errcnt  <= '0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         if (state == IDLE && arb_valid) begin
            core_q  <= arb_core;
            src_d_q <= arb_d;
            wr_q    <= arb_w;
            addr_q  <= arb_addr;
            data_q  <= arb_data;
            tmo_cnt <= '0;
         end else if (state == ACCESS) begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end
         if (done) begin
            iload_q <= bus.iload;
            dload_q <= bus.dload;
            if (src_d_q)
               rr_ptr <= (core_q == CW'(NCPU-1)) ? '0 : core_q + CW'(1);
         end
         if (abort_err && errcnt != 8'hFF)
            errcnt <= errcnt + 8'd1;
      end
   end
endmodule

// File: tb/tb_mem_responder.sv
// Directed vector bench for mem_responder: per-cycle table plus timeout/reset/saturation sequences.
module tb_mem_responder;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

   logic       CLK;
   logic       RST;
   logic [7:0] errcnt;
   int         n_vec;
   int         n_bad;

   mem_responder_if #(.NCPU(2)) bus();

   mem_responder #(.NCPU(2), .TIMEOUT(64)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .bus    (bus),
      .errcnt (errcnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [1:0]  dren;
      logic [1:0]  dwen;
      logic [1:0]  iren;
      logic [1:0]  rs;
      logic [31:0] rload;
      logic        e_ren;
      logic        e_wen;
      logic [31:0] e_addr;
      logic [31:0] e_store;
      logic [1:0]  e_dwait;
      logic [1:0]  e_iwait;
      logic [31:0] e_dload0;
      logic [7:0]  e_err;
   } vec_t;

   vec_t vt[$];

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] dren, input logic [1:0] dwen, input logic [1:0] iren,
                      input logic [1:0] rs, input logic [31:0] rload,
                      input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                      input logic [31:0] e_store, input logic [1:0] e_dwait, input logic [1:0] e_iwait,
                      input logic [31:0] e_dload0, input logic [7:0] e_err);
      vec_t v;
      v = '{dren, dwen, iren, rs, rload, e_ren, e_wen, e_addr, e_store, e_dwait, e_iwait, e_dload0, e_err};
      vt.push_back(v);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      RST = 1'b1;
      bus.dREN = '0; bus.dWEN = '0; bus.iREN = '0;
      bus.daddr  = {32'h0000_0080, 32'h0000_0040};
      bus.dstore = {32'h0000_1234, 32'h0000_5555};
      bus.iaddr  = {32'h0000_0300, 32'h0000_0200};
      bus.ramstate = BUSY;
      bus.ramload  = '0;

      //   dREN   dWEN   iREN   rs    ramload        REN WEN addr      store     dwait  iwait  dload0         err
      add(2'b00, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'h0,         8'd0); // reset state
      add(2'b01, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'h0,         8'd0);
      add(2'b01, 2'b00, 2'b00, BUSY, 32'h0,         1, 0, 32'h40,  32'h0,    2'b11, 2'b11, 32'h0,         8'd0);
      add(2'b01, 2'b00, 2'b00, BUSY, 32'h0,         1, 0, 32'h40,  32'h0,    2'b11, 2'b11, 32'h0,         8'd0);
      add(2'b01, 2'b00, 2'b00, ACC,  32'hDEADBEEF,  1, 0, 32'h40,  32'h0,    2'b10, 2'b11, 32'hDEADBEEF,  8'd0);
      add(2'b00, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hDEADBEEF,  8'd0);
      add(2'b00, 2'b10, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hDEADBEEF,  8'd0); // write d1
      add(2'b00, 2'b10, 2'b00, ACC,  32'h0,         0, 1, 32'h80,  32'h1234, 2'b01, 2'b11, 32'hDEADBEEF,  8'd0);
      add(2'b00, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hDEADBEEF,  8'd0);
      // contention: d0,d1,d0,d1 while icache waits
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hDEADBEEF,  8'd0);
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  1, 0, 32'h40,  32'h0,    2'b10, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  1, 0, 32'h80,  32'h0,    2'b01, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  1, 0, 32'h40,  32'h0,    2'b10, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b11, 2'b00, 2'b11, ACC,  32'hCAFE0000,  1, 0, 32'h80,  32'h0,    2'b01, 2'b11, 32'hCAFE0000,  8'd0);
      // icache only: i0, i0, then i1 once i0 drops
      add(2'b00, 2'b00, 2'b11, ACC,  32'hCAFE0000,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b00, 2'b00, 2'b11, ACC,  32'hCAFE0000,  1, 0, 32'h200, 32'h0,    2'b11, 2'b10, 32'hCAFE0000,  8'd0);
      add(2'b00, 2'b00, 2'b11, ACC,  32'hCAFE0000,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b00, 2'b00, 2'b11, ACC,  32'hCAFE0000,  1, 0, 32'h200, 32'h0,    2'b11, 2'b10, 32'hCAFE0000,  8'd0);
      add(2'b00, 2'b00, 2'b10, ACC,  32'hCAFE0000,  0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b00, 2'b00, 2'b10, ACC,  32'hCAFE0000,  1, 0, 32'h300, 32'h0,    2'b11, 2'b01, 32'hCAFE0000,  8'd0);
      add(2'b00, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      // ERROR abort then retry
      add(2'b01, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b01, 2'b00, 2'b00, ERR,  32'h0,         1, 0, 32'h40,  32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd0);
      add(2'b01, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'hCAFE0000,  8'd1);
      add(2'b01, 2'b00, 2'b00, ACC,  32'h0BADF00D,  1, 0, 32'h40,  32'h0,    2'b10, 2'b11, 32'h0BADF00D,  8'd1);
      // withdrawal: abort without errcnt
      add(2'b01, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'h0BADF00D,  8'd1);
      add(2'b00, 2'b00, 2'b00, BUSY, 32'h0,         1, 0, 32'h40,  32'h0,    2'b11, 2'b11, 32'h0BADF00D,  8'd1);
      add(2'b00, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'h0BADF00D,  8'd1);
      // dREN+dWEN together is a write
      add(2'b01, 2'b01, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'h0BADF00D,  8'd1);
      add(2'b01, 2'b01, 2'b00, ACC,  32'hFFFFFFFF,  0, 1, 32'h40,  32'h5555, 2'b10, 2'b11, 32'h0BADF00D,  8'd1);
      add(2'b00, 2'b00, 2'b00, BUSY, 32'h0,         0, 0, 32'h0,   32'h0,    2'b11, 2'b11, 32'h0BADF00D,  8'd1);

      step();
      step();
      RST = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         bus.dREN = vt[i].dren;
         bus.dWEN = vt[i].dwen;
         bus.iREN = vt[i].iren;
         bus.ramstate = vt[i].rs;
         bus.ramload  = vt[i].rload;
         #1;
         chk($sformatf("v%0d ramREN", i),   32'(bus.ramREN),   32'(vt[i].e_ren));
         chk($sformatf("v%0d ramWEN", i),   32'(bus.ramWEN),   32'(vt[i].e_wen));
         chk($sformatf("v%0d ramaddr", i),  bus.ramaddr,       vt[i].e_addr);
         chk($sformatf("v%0d ramstore", i), bus.ramstore,      vt[i].e_store);
         chk($sformatf("v%0d dwait", i),    32'(bus.dwait),    32'(vt[i].e_dwait));
         chk($sformatf("v%0d iwait", i),    32'(bus.iwait),    32'(vt[i].e_iwait));
         chk($sformatf("v%0d dload0", i),   bus.dload[31:0],   vt[i].e_dload0);
         chk($sformatf("v%0d errcnt", i),   32'(errcnt),       32'(vt[i].e_err));
         step();
      end

      // timeout: 64 BUSY cycles in ACCESS, then abort and retry
      bus.dREN = 2'b01; bus.dWEN = 2'b00; bus.iREN = 2'b00;
      bus.ramstate = BUSY;
      #1;
      chk("to idle ramREN", 32'(bus.ramREN), 32'd0);
      step();
      for (int k = 1; k <= 64; k++) begin
         chk($sformatf("to cyc%0d ramREN", k), 32'(bus.ramREN), 32'd1);
         chk($sformatf("to cyc%0d dwait", k), 32'(bus.dwait), 32'd3);
         step();
      end
      chk("to abort ramREN", 32'(bus.ramREN), 32'd0);
      chk("to abort errcnt", 32'(errcnt), 32'd2);
      step();
      chk("to retry ramREN", 32'(bus.ramREN), 32'd1);

      // reset mid-ACCESS, RAM answering in the same cycle
      RST = 1'b1;
      bus.ramstate = ACC;
      #1;
      chk("rst no ack dwait", 32'(bus.dwait), 32'd3);
      step();
      RST = 1'b0;
      bus.dREN = 2'b00;
      bus.ramstate = BUSY;
      #1;
      chk("rst ramREN", 32'(bus.ramREN), 32'd0);
      chk("rst ramWEN", 32'(bus.ramWEN), 32'd0);
      chk("rst dwait", 32'(bus.dwait), 32'd3);
      chk("rst iwait", 32'(bus.iwait), 32'd3);
      chk("rst errcnt", 32'(errcnt), 32'd0);
      chk("rst dload0", bus.dload[31:0], 32'd0);
      step();

      // errcnt saturation
      bus.dREN = 2'b01;
      for (int k = 0; k < 260; k++) begin
         bus.ramstate = BUSY;
         step();
         bus.ramstate = ERR;
         step();
      end
      bus.dREN = 2'b00;
      bus.ramstate = BUSY;
      #1;
      chk("sat errcnt", 32'(errcnt), 32'd255);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
